mem_resp_slave: RTL and testbench

Synthesizable single-port word memory acting as the responder end of the core's req/gnt/rvalid instruction/data memory protocol. Grants requests after a configurable number of wait states and returns read data or write acknowledge one cycle after grant. Supports byte enables and flags out-of-range accesses with an error response. Drop-in target for the instr and data ports of zeroriscy_core in benches and FPGA builds.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/mem_resp_lfsr.sv | 23 ++
 rtl/mem_resp_slave.sv | 149 ++++++++++++++
 tb/tb_mem_resp_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the req/gnt/rvalid memory responder.
// Optional build macro used by the top: MEM_RESP_RANDOM_STALL_EN.
package mem_resp_pkg;

  localparam int          BE_WIDTH  = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [BE_WIDTH-1:0] be;
    logic [31:0]         wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_resp_lfsr.sv
// Pseudo-random grant stall source: 16-bit Fibonacci LFSR, stall = lfsr[0].
// Only instantiated when MEM_RESP_RANDOM_STALL_EN is defined.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign stall_o = lfsr_q[0];

endmodule

// File: rtl/mem_resp_slave.sv
// Single-port word memory responding on the req/gnt/rvalid protocol with wait states.
// Build macro: MEM_RESP_RANDOM_STALL_EN adds LFSR-driven random grant stalls.
module mem_resp_slave
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int GNT_WAIT    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  port_req_i,
  output logic                  port_gnt_o,
  output logic                  port_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] port_addr_i,
  input  logic                  port_we_i,
  input  logic [BE_WIDTH-1:0]   port_be_i,
  input  logic [DATA_WIDTH-1:0] port_wdata_i,
  output logic [DATA_WIDTH-1:0] port_rdata_o,
  output logic                  port_err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (GNT_WAIT > 1) ? $clog2(GNT_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX   = GNT_WAIT[CNT_W-1:0];
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = DEPTH_WORDS[ADDR_WIDTH-3:0];

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_WAIT = 1'(WAIT);

  // Handshake: a request transfers in the cycle req && gnt are both high; the
  // response follows one cycle later as a single-cycle rvalid pulse (no backpressure).

  mem_req_t              cur_req;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  unused_addr_bits;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_ok;
  logic             stall;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  assign cur_req = '{addr: 32'(port_addr_i), we: port_we_i, be: port_be_i,
                     wdata: port_wdata_i};
  assign word_idx         = cur_req.addr[ADDR_WIDTH-1:2];
  assign mem_idx          = word_idx[IDX_W-1:0];
  assign in_range         = (word_idx < DEPTH_LIM);
  assign unused_addr_bits = ^cur_req.addr[1:0];

`ifdef MEM_RESP_RANDOM_STALL_EN
  mem_resp_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // A stalled grant parks at terminal count in WAIT so it fires on the next free cycle.
  always_comb begin
    grant_ok = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (port_req_i) begin
          if (GNT_WAIT == 0) begin
            grant_ok = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!port_req_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          grant_ok = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (grant_ok && !stall) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (grant_ok) begin
      state_d = ST_WAIT;
      cnt_d   = CNT_MAX;
    end
  end

  assign port_gnt_o = grant_ok & ~stall & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (port_gnt_o && cur_req.we && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (cur_req.be[b]) begin
          mem[mem_idx][8*b +: 8] <= cur_req.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= port_gnt_o;
      if (port_gnt_o) begin
        err_q   <= ~in_range;
        rdata_q <= (cur_req.we || !in_range) ? '0 : mem[mem_idx];
      end
    end
  end

  assign port_rvalid_o = rvalid_q;
  assign port_rdata_o  = rdata_q;
  assign port_err_o    = err_q;

endmodule

// File: tb/tb_mem_resp_slave.sv
// Bench for mem_resp_slave: one instance with GNT_WAIT=0, one with GNT_WAIT=3.
module tb_mem_resp_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [3:0]  be[2];
  logic [31:0] wdata[2];
  logic        gnt[2];
  logic        rvalid[2];
  logic [31:0] rdata[2];
  logic        err[2];

  mem_resp_slave #(.GNT_WAIT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .port_req_i(req[0]), .port_gnt_o(gnt[0]),
    .port_rvalid_o(rvalid[0]), .port_addr_i(addr[0]), .port_we_i(we[0]),
    .port_be_i(be[0]), .port_wdata_i(wdata[0]), .port_rdata_o(rdata[0]),
    .port_err_o(err[0])
  );

  mem_resp_slave #(.GNT_WAIT(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .port_req_i(req[1]), .port_gnt_o(gnt[1]),
    .port_rvalid_o(rvalid[1]), .port_addr_i(addr[1]), .port_we_i(we[1]),
    .port_be_i(be[1]), .port_wdata_i(wdata[1]), .port_rdata_o(rdata[1]),
    .port_err_o(err[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: word array per instance, held-request counter, response queues.
  logic [31:0] mdl[2][1024];
  int          held[2];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          rv_cnt[2];
  int          gnt_cnt[2];
  logic [31:0] last_rd[2];
  logic        last_err[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_cycle(input int d);
    logic [32:0] e;
    bit          have;
    logic        g_exp;
    int          gw;
    int          idx;
    e    = '0;
    have = 1'b0;
    if (d == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
    if (d == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
    if (rst) have = 1'b0;
    chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(have));
    if (rvalid[d]) begin
      rv_cnt[d]++;
      last_rd[d]  = rdata[d];
      last_err[d] = err[d];
    end
    if (have) begin
      chk($sformatf("rdata%0d", d), rdata[d], e[31:0]);
      chk($sformatf("err%0d", d), 32'(err[d]), 32'(e[32]));
    end
    if (rst) begin
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'h0);
    end
    gw    = (d == 0) ? 0 : 3;
    g_exp = !rst && req[d] && (held[d] == gw);
    chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(g_exp));
    if (gnt[d]) gnt_cnt[d]++;
    if (rst || !req[d] || g_exp) held[d] = 0;
    else held[d]++;
    if (g_exp) begin
      idx = int'(addr[d] >> 2);
      if (idx >= 1024) begin
        e = {1'b1, 32'h0};
      end else if (we[d]) begin
        for (int b = 0; b < 4; b++)
          if (be[d][b]) mdl[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
        e = 33'h0;
      end else begin
        e = {1'b0, mdl[d][idx]};
      end
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_cycle(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until granted; returns just after the gnt edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd,
                       input bit hold, output int waits);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    waits = 0;
    #1;
    while (!gnt[d] && waits < 20) begin
      @(posedge clk);
      #2;
      waits++;
    end
    if (waits >= 20) chk("gnt_timeout", 32'(gnt[d]), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req[d] = 1'b0;
  endtask

  initial begin
    int w;
    int base_rv, base_g;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
      held[d] = 0; rv_cnt[d] = 0; gnt_cnt[d] = 0; last_rd[d] = '0; last_err[d] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rvalid", 32'(rvalid[0]), 32'h0);
    tick();

    // Full-word write then read, zero wait states
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, w);
    chk("w10_wait", 32'(w), 32'd0);
    tick();
    chk("w10_err", 32'(last_err[0]), 32'h0);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, w);
    chk("r10_wait", 32'(w), 32'd0);
    tick();
    chk("r10_data", last_rd[0], 32'hDEADBEEF);
    chk("r10_err", 32'(last_err[0]), 32'h0);

    // Byte enables plus a be=0000 no-op write
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, w); tick();
    issue(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b0, w); tick();
    issue(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, w); tick();
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, w); tick();
    chk("be_merge", last_rd[0], 32'h11BB33DD);

    // Back-to-back reads with req held
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 32'(4 * i), 4'hF, 32'hCAFE0000 + 32'(i), 1'b0, w);
      tick();
    end
    base_rv = rv_cnt[0];
    base_g  = gnt_cnt[0];
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'(4 * i), 4'h0, 32'h0, (i < 3), w);
      chk("b2b_wait", 32'(w), 32'd0);
    end
    tick();
    chk("b2b_gnts", 32'(gnt_cnt[0] - base_g), 32'd4);
    chk("b2b_rvalids", 32'(rv_cnt[0] - base_rv), 32'd4);
    chk("b2b_last", last_rd[0], 32'hCAFE0003);

    // Out-of-range accesses must not alias onto word 0
    issue(0, 1'b1, 32'h1000, 4'hF, 32'h55555555, 1'b0, w); tick();
    chk("oor_w_err", 32'(last_err[0]), 32'h1);
    chk("oor_w_data", last_rd[0], 32'h0);
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0, w); tick();
    chk("oor_r_err", 32'(last_err[0]), 32'h1);
    chk("oor_r_data", last_rd[0], 32'h0);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, w); tick();
    chk("word0_intact", last_rd[0], 32'hCAFE0000);
    chk("word0_err", 32'(last_err[0]), 32'h0);

    // Three wait states
    issue(1, 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b0, w);
    chk("gw3_w_wait", 32'(w), 32'd3);
    tick();
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, w);
    chk("gw3_r_wait", 32'(w), 32'd3);
    tick();
    chk("gw3_r_data", last_rd[1], 32'h12345678);

    // Abandoned requests after one and after two cycles
    base_g  = gnt_cnt[1];
    base_rv = rv_cnt[1];
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    tick();
    req[1] = 1'b0;
    tick(); tick();
    req[1] = 1'b1;
    tick(); tick();
    req[1] = 1'b0;
    tick(); tick();
    chk("abandon_gnt", 32'(gnt_cnt[1] - base_g), 32'd0);
    chk("abandon_rvalid", 32'(rv_cnt[1] - base_rv), 32'd0);
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, w);
    chk("after_abandon_wait", 32'(w), 32'd3);
    tick();
    chk("after_abandon_data", last_rd[1], 32'h12345678);

    // Reset between gnt and rvalid drops the response; memory survives
    base_rv = rv_cnt[0];
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, w);
    rst = 1'b1;
    tick(); tick();
    chk("rst_drop", 32'(rv_cnt[0] - base_rv), 32'd0);
    chk("rst_gnt", 32'(gnt[0]), 32'h0);
    rst = 1'b0;
    tick();
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, w); tick();
    chk("post_rst_data", last_rd[0], 32'hDEADBEEF);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, w); tick();
    chk("post_rst_be", last_rd[0], 32'h11BB33DD);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
